// File: rtl/euler_result_uart_if.sv
// Solver-to-reporter bundle: the solver drives result/done, the reporter drives tx/busy/sent.
interface euler_result_uart_if;
    logic [31:0] result;
    logic        done;
    logic        tx;
    logic        busy;
    logic        sent;

    modport master (
        output result,
        output done,
        input  tx,
        input  busy,
        input  sent
    );

    modport slave (
        input  result,
        input  done,
        output tx,
        output busy,
        output sent
    );
endinterface

// File: rtl/euler_result_uart.sv
// Captures a solver result on done, converts it to decimal ASCII + CR LF and sends it once per reset (8N1, no backpressure).
// Conversion takes at most 100 cycles; EULER_UART_PARITY_EN adds an even-parity bit per frame (8E1).
module euler_result_uart #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                clk,
    input  logic                rst,
    euler_result_uart_if.slave  bus
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);

`ifdef EULER_UART_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd10;
`else
    localparam logic [3:0] LAST_BIT = 4'd9;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_SEND,
        S_FIN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [31:0]      r_work;
    logic [3:0]       r_k;
    logic [3:0]       r_digit;
    logic             r_started;
    logic [9:0][3:0]  r_buf;
    logic [3:0]       r_cnt;

    logic [3:0]       r_char_idx;
    logic [3:0]       r_bit_idx;
    logic [TW-1:0]    r_timer;

    logic             r_tx;
    logic             r_busy;
    logic             r_sent;

    logic [31:0]      w_pow;
    logic             w_ge;
    logic             w_conv_last;
    logic             w_keep_digit;
    logic [7:0]       w_char;
    logic             w_bit_end;
    logic             w_frame_end;
    logic             w_last_char;

    function automatic logic [31:0] pow10(input logic [3:0] k);
        logic [31:0] p;
        case (k)
            4'd0:    p = 32'd1;
            4'd1:    p = 32'd10;
            4'd2:    p = 32'd100;
            4'd3:    p = 32'd1000;
            4'd4:    p = 32'd10000;
            4'd5:    p = 32'd100000;
            4'd6:    p = 32'd1000000;
            4'd7:    p = 32'd10000000;
            4'd8:    p = 32'd100000000;
            4'd9:    p = 32'd1000000000;
            default: p = 32'd1;
        endcase
        return p;
    endfunction

    // Bit 0 is the start bit, 1..8 carry data LSB first, then optional parity, then stop.
    function automatic logic frame_bit(input logic [7:0] ch, input logic [3:0] idx);
        logic b;
        b = 1'b1;
        if (idx == 4'd0) begin
            b = 1'b0;
        end else if (idx <= 4'd8) begin
            b = ch[3'(idx - 4'd1)];
        end
`ifdef EULER_UART_PARITY_EN
        else if (idx == 4'd9) begin
            b = ^ch;
        end
`endif
        return b;
    endfunction

    assign w_pow        = pow10(r_k);
    assign w_ge         = (r_work >= w_pow);
    assign w_conv_last  = !w_ge && (r_k == 4'd0);
    assign w_keep_digit = (r_digit != 4'd0) || r_started || (r_k == 4'd0);

    always_comb begin
        w_char = 8'h0A;
        if (r_char_idx < r_cnt) begin
            w_char = 8'h30 + {4'h0, r_buf[r_char_idx]};
        end else if (r_char_idx == r_cnt) begin
            w_char = 8'h0D;
        end
    end

    assign w_bit_end   = (r_timer == TIMER_MAX);
    assign w_frame_end = w_bit_end && (r_bit_idx == LAST_BIT);
    assign w_last_char = (r_char_idx == (r_cnt + 4'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.done)                   w_state_nxt = S_CONV;
            S_CONV:  if (w_conv_last)                w_state_nxt = S_SEND;
            S_SEND:  if (w_frame_end && w_last_char) w_state_nxt = S_FIN;
            S_FIN:                                   w_state_nxt = S_FIN;
            default:                                 w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work     <= '0;
            r_k        <= '0;
            r_digit    <= '0;
            r_started  <= 1'b0;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_char_idx <= '0;
            r_bit_idx  <= '0;
            r_timer    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_sent     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.done) begin
                        r_work    <= bus.result;
                        r_k       <= 4'd9;
                        r_digit   <= '0;
                        r_started <= 1'b0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                    end
                end

                S_CONV: begin
                    if (w_ge) begin
                        r_work  <= r_work - w_pow;
                        r_digit <= r_digit + 4'd1;
                    end else begin
                        // Leading zeros are dropped; the units digit is always kept so 0 prints as "0".
                        if (w_keep_digit) begin
                            r_buf[r_cnt] <= r_digit;
                            r_cnt        <= r_cnt + 4'd1;
                            r_started    <= 1'b1;
                        end
                        r_digit <= '0;
                        if (r_k == 4'd0) begin
                            r_char_idx <= '0;
                            r_bit_idx  <= '0;
                            r_timer    <= '0;
                            r_tx       <= 1'b0;
                        end else begin
                            r_k <= r_k - 4'd1;
                        end
                    end
                end

                S_SEND: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (r_bit_idx == LAST_BIT) begin
                            r_bit_idx <= '0;
                            if (w_last_char) begin
                                r_tx   <= 1'b1;
                                r_busy <= 1'b0;
                                r_sent <= 1'b1;
                            end else begin
                                // Next start bit directly after the stop bit: no idle gap.
                                r_char_idx <= r_char_idx + 4'd1;
                                r_tx       <= 1'b0;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                            r_tx      <= frame_bit(w_char, r_bit_idx + 4'd1);
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_FIN: begin
                    r_tx <= 1'b1;
                end

                default: begin
                    r_tx <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx   = r_tx;
    assign bus.busy = r_busy;
    assign bus.sent = r_sent;

endmodule

// File: tb/tb_euler_result_uart.sv
// Directed bench for euler_result_uart: decodes tx mid-bit at CLKS_PER_BIT=4 and compares against hand-written reports.
`timescale 1ns/1ps
module tb_euler_result_uart;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    euler_result_uart_if bus();

    euler_result_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    logic par_log [0:11];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        bus.done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic watch_quiet(input string tag, input int cycles, input logic exp_sent);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.sent !== exp_sent) bad++;
        end
        chk(tag, bad, 32'd0);
    endtask

    // Starts polling at a negedge; gap counts negedges until the start bit is seen.
    task automatic recv_byte(input string tag, output logic [7:0] b, output logic par, output int gap);
        b   = 8'h00;
        par = 1'b0;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (bus.tx !== 1'b0 && gap < 400);
        chk({tag, "_start"}, {31'b0, bus.tx}, 32'd0);
        if (bus.tx !== 1'b0) return;
        @(negedge clk);
        chk({tag, "_start_mid"}, {31'b0, bus.tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = bus.tx;
        end
`ifdef EULER_UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        par = bus.tx;
        chk({tag, "_parity"}, {31'b0, par}, {31'b0, ^b});
`endif
        repeat (CPB) @(negedge clk);
        chk({tag, "_stop"}, {31'b0, bus.tx}, 32'd1);
    endtask

    // Call right after a negedge; the following posedge is the capture edge.
    task automatic run_report(input string name, input logic [31:0] val, input string digits,
                              input bit pulse, input logic [31:0] alt);
        logic [7:0] exp_q [$];
        logic [7:0] b;
        logic       par;
        int         gap;
        for (int i = 0; i < digits.len(); i++) exp_q.push_back(digits[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        bus.result = val;
        bus.done   = 1'b1;
        @(negedge clk);
        if (pulse) begin
            bus.done   = 1'b0;
            bus.result = alt;
        end
        chk({name, "_busy_on_capture"}, {31'b0, bus.busy}, 32'd1);
        chk({name, "_sent_on_capture"}, {31'b0, bus.sent}, 32'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            recv_byte($sformatf("%s_f%0d", name, i), b, par, gap);
            chk($sformatf("%s_byte%0d", name, i), {24'b0, b}, {24'b0, exp_q[i]});
            if (i == 0) chk({name, "_conv_le_100"}, {31'b0, (gap <= 100)}, 32'd1);
            else        chk($sformatf("%s_gap%0d", name, i), gap, 32'd3);
            if (i < 12) par_log[i] = par;
        end
        chk({name, "_busy_in_last_stop"}, {31'b0, bus.busy}, 32'd1);
        chk({name, "_sent_in_last_stop"}, {31'b0, bus.sent}, 32'd0);
        repeat (3) @(negedge clk);
        chk({name, "_sent_fin"}, {31'b0, bus.sent}, 32'd1);
        chk({name, "_busy_fin"}, {31'b0, bus.busy}, 32'd0);
        chk({name, "_tx_fin"},   {31'b0, bus.tx},   32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic       par;
        int         gap;

        bus.result = 32'd0;
        bus.done   = 1'b0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx",   {31'b0, bus.tx},   32'd1);
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        chk("reset_sent", {31'b0, bus.sent}, 32'd0);
        rst = 1'b0;

        bus.result = 32'd12345;
        watch_quiet("idle_1000", 1000, 1'b0);

        run_report("big", 32'd25164150, "25164150", 1'b0, 32'd0);
        watch_quiet("no_retrigger_held", 100, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.result = $urandom;
            bus.done   = ~bus.done;
        end
        watch_quiet("no_retrigger_toggle", 200, 1'b1);

        do_reset();
        run_report("zero", 32'd0, "0", 1'b0, 32'd0);

        do_reset();
        run_report("max", 32'hFFFFFFFF, "4294967295", 1'b0, 32'd0);

        do_reset();
        run_report("pulse", 32'd7, "7", 1'b1, 32'd9);

        do_reset();
        run_report("two", 32'd2, "2", 1'b0, 32'd0);
`ifdef EULER_UART_PARITY_EN
        chk("two_parity_0x32", {31'b0, par_log[0]}, 32'd1);
        chk("two_parity_0x0A", {31'b0, par_log[2]}, 32'd0);
`endif

        // Reset during data bit 2 of the third frame ('3' = 0x33, bit 2 is 0).
        do_reset();
        bus.result = 32'd123;
        bus.done   = 1'b1;
        recv_byte("rst_f0", b, par, gap);
        chk("rst_byte0", {24'b0, b}, 32'h31);
        recv_byte("rst_f1", b, par, gap);
        chk("rst_byte1", {24'b0, b}, 32'h32);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (bus.tx !== 1'b0 && gap < 400);
        chk("rst_f2_start", {31'b0, bus.tx}, 32'd0);
        repeat (13) @(negedge clk);
        chk("rst_f2_bit2", {31'b0, bus.tx}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_tx_immediate",   {31'b0, bus.tx},   32'd1);
        chk("rst_busy_immediate", {31'b0, bus.busy}, 32'd0);
        chk("rst_sent_immediate", {31'b0, bus.sent}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_report("rerun", 32'd123, "123", 1'b0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
